// File: rtl/lcd_char_feeder_pkg.sv
// -----------------------------------------------------------------------------
// lcd_char_feeder_pkg
//   Shared definitions for the character feeder in front of the LCD writer:
//   character and retry-counter widths, FSM state encoding and a small helper
//   that classifies the "character in flight" states.
// -----------------------------------------------------------------------------
package lcd_char_feeder_pkg;

    localparam int CHAR_W  = 8;     // character code width
    localparam int RETRY_W = 8;     // saturating retry counter width

    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    typedef enum logic [2:0] {
        FEED_WAIT_INIT = 3'd0,  // LCD power-on sequence not finished
        FEED_IDLE      = 3'd1,  // waiting for a character and a ready writer
        FEED_ISSUE     = 3'd2,  // strobe cycle, head is popped
        FEED_WAIT_BUSY = 3'd3,  // waiting for the writer to acknowledge (ready low)
        FEED_WAIT_DONE = 3'd4   // writer busy, waiting for it to return to idle
    } feed_state_e;

    // A character is in flight from the strobe until the writer finishes it.
    function automatic logic is_busy_state(input feed_state_e s);
        return (s == FEED_ISSUE) || (s == FEED_WAIT_BUSY) || (s == FEED_WAIT_DONE);
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// -----------------------------------------------------------------------------
// lcd_char_fifo
//   First-word-fall-through character FIFO. The oldest entry is always visible
//   on head_o while the FIFO is non-empty. Occupancy flags and the count are
//   registered; a push is judged against the occupancy at the start of the
//   cycle, so a push into a full FIFO is dropped even if a pop happens in the
//   same cycle. Dropped pushes set the sticky overflow flag.
//
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous, active-high reset
//   push_i       in   write push_data_i this cycle
//   push_data_i  in   W   data to write
//   pop_i        in   remove the head entry this cycle
//   head_o       out  W   oldest entry (valid while !empty_o)
//   full_o       out  DEPTH entries held
//   empty_o      out  no entries held
//   count_o      out  $clog2(DEPTH)+1  occupancy
//   overflow_o   out  sticky: a push was dropped
// -----------------------------------------------------------------------------
module lcd_char_fifo
    import lcd_char_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = CHAR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & full_q);

        // DEPTH is a power of two, so the pointers wrap by overflowing.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/lcd_char_feeder.sv
// -----------------------------------------------------------------------------
// lcd_char_feeder
//   Buffers character codes from any producer and hands them one at a time to
//   the character LCD writer. Nothing is issued until the writer reports its
//   power-on sequence complete. Tracks the display column of the next
//   character and retries a strobe the writer did not acknowledge in time.
//
//   Clock              in   clock, rising edge
//   Reset              in   synchronous, active-high reset
//   iPush, iPushData   in   producer strobe and 8-bit character
//   oFull, oEmpty      out  FIFO occupancy flags
//   oCount             out  FIFO occupancy
//   oOverflow          out  sticky: a push was dropped (cleared by Reset only)
//   iLCD_Ready         in   writer is idle
//   iLCD_Initialized   in   writer power-on sequence complete
//   oLCD_WriteEnabled  out  one-cycle write strobe
//   oLCD_Data          out  character presented with the strobe (held)
//   oColumn            out  column of the next character
//   oBusy              out  a character is in flight
//   oRetryCount        out  saturating count of acknowledge-timeout retries
// -----------------------------------------------------------------------------
module lcd_char_feeder
    import lcd_char_feeder_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int COLS        = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iPush,
    input  logic [CHAR_W-1:0]         iPushData,
    output logic                      oFull,
    output logic                      oEmpty,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oOverflow,
    input  logic                      iLCD_Ready,
    input  logic                      iLCD_Initialized,
    output logic                      oLCD_WriteEnabled,
    output logic [CHAR_W-1:0]         oLCD_Data,
    output logic [$clog2(COLS)-1:0]   oColumn,
    output logic                      oBusy,
    output logic [RETRY_W-1:0]        oRetryCount
);

    localparam int CLW = $clog2(COLS);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);

    feed_state_e          state_q, state_d;
    logic                 strobe_q, strobe_d;
    logic [CHAR_W-1:0]    data_q, data_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CLW-1:0]       col_q, col_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;

    logic                 fifo_pop;
    logic [CHAR_W-1:0]    fifo_head;
    logic                 fifo_empty;

    // Only the first strobe of a character pops; retries re-send data_q.
    assign fifo_pop = strobe_q && (state_q == FEED_ISSUE);

    lcd_char_fifo #(
        .DEPTH (DEPTH),
        .W     (CHAR_W)
    ) u_fifo (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .push_i      (iPush),
        .push_data_i (iPushData),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (oFull),
        .empty_o     (fifo_empty),
        .count_o     (oCount),
        .overflow_o  (oOverflow)
    );

    // The strobe is a registered output, so the decision to strobe is taken on
    // the edge that enters ISSUE (or re-arms it); the writer's ready is checked
    // there, which is the same cycle the strobe would otherwise be qualified.
    // The acknowledge timer is loaded with each strobe and counts the strobe
    // cycle itself, so an unacknowledged strobe repeats every ACK_TIMEOUT cycles.
    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        data_d   = data_q;
        timer_d  = timer_q;
        col_d    = col_q;
        retry_d  = retry_q;

        case (state_q)
            FEED_WAIT_INIT: begin
                if (iLCD_Initialized) state_d = FEED_IDLE;
            end

            FEED_IDLE: begin
                if (!fifo_empty && iLCD_Ready) begin
                    state_d  = FEED_ISSUE;
                    strobe_d = 1'b1;
                    data_d   = fifo_head;
                    timer_d  = TW'(ACK_TIMEOUT);
                end
            end

            FEED_ISSUE: begin
                if (strobe_q) begin
                    state_d = FEED_WAIT_BUSY;
                    timer_d = timer_q - 1'b1;
                end else if (fifo_empty) begin
                    state_d = FEED_IDLE;
                end else if (iLCD_Ready) begin
                    // Not strobed yet: hold here until the writer is ready.
                    strobe_d = 1'b1;
                    data_d   = fifo_head;
                    timer_d  = TW'(ACK_TIMEOUT);
                end
            end

            FEED_WAIT_BUSY: begin
                if (!iLCD_Ready) begin
                    state_d = FEED_WAIT_DONE;
                end else if (timer_q <= TW'(1)) begin
                    strobe_d = 1'b1;
                    timer_d  = TW'(ACK_TIMEOUT);
                    if (retry_q != RETRY_MAX) retry_d = retry_q + 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            FEED_WAIT_DONE: begin
                if (iLCD_Ready) begin
                    state_d = FEED_IDLE;
                    col_d   = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;
                end
            end

            default: state_d = FEED_WAIT_INIT;
        endcase

        // Losing initialization aborts whatever is in flight; queued characters stay.
        if (!iLCD_Initialized) begin
            state_d  = FEED_WAIT_INIT;
            strobe_d = 1'b0;
            data_d   = data_q;
            col_d    = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= FEED_WAIT_INIT;
            strobe_q <= 1'b0;
            data_q   <= '0;
            timer_q  <= '0;
            col_q    <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            col_q    <= col_d;
            retry_q  <= retry_d;
        end
    end

    assign oEmpty            = fifo_empty;
    assign oLCD_WriteEnabled = strobe_q;
    assign oLCD_Data         = data_q;
    assign oColumn           = col_q;
    assign oRetryCount       = retry_q;
    assign oBusy             = is_busy_state(state_q);

endmodule

// File: tb/tb_lcd_char_feeder.sv
module tb_lcd_char_feeder;

    localparam int DEPTH = 16;
    localparam int COLS  = 16;
    localparam int ACK   = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iPush;
    logic [7:0] iPushData;
    logic       oFull, oEmpty, oOverflow;
    logic [4:0] oCount;
    logic       iLCD_Ready, iLCD_Initialized;
    logic       oLCD_WriteEnabled;
    logic [7:0] oLCD_Data;
    logic [3:0] oColumn;
    logic       oBusy;
    logic [7:0] oRetryCount;

    always #5 Clock = ~Clock;

    lcd_char_feeder #(.DEPTH(DEPTH), .COLS(COLS), .ACK_TIMEOUT(ACK)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iPush             (iPush),
        .iPushData         (iPushData),
        .oFull             (oFull),
        .oEmpty            (oEmpty),
        .oCount            (oCount),
        .oOverflow         (oOverflow),
        .iLCD_Ready        (iLCD_Ready),
        .iLCD_Initialized  (iLCD_Initialized),
        .oLCD_WriteEnabled (oLCD_WriteEnabled),
        .oLCD_Data         (oLCD_Data),
        .oColumn           (oColumn),
        .oBusy             (oBusy),
        .oRetryCount       (oRetryCount)
    );

    typedef struct {
        logic [7:0] data;
        int         col;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   strobe_cnt = 0;
    int   next_col   = 0;
    int   wr_en      = 0;   // 0: writer holds ready low
    int   hold_cyc   = 0;   // cycles ready stays high after a strobe
    int   busy_cyc   = 3;   // cycles ready stays low while "writing"

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_char(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.col  = next_col % COLS;
        exp_q.push_back(e);
        next_col++;
    endtask

    task automatic expect_retry(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.col  = (next_col - 1) % COLS;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe consumes one expected entry.
    always @(negedge Clock) begin : mon
        exp_t e;
        if (!Reset && oLCD_WriteEnabled) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: data 0x%02h col %0d, nothing expected", oLCD_Data, oColumn);
            end else begin
                e = exp_q.pop_front();
                check("strobe_data", int'(oLCD_Data), int'(e.data));
                check("strobe_col", int'(oColumn), e.col);
            end
        end
    end

    // Writer model: ready high when idle, drops busy_cyc cycles after hold_cyc.
    initial begin : writer
        int wst;
        int wcnt;
        wst = 0;
        wcnt = 0;
        iLCD_Ready = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (wr_en == 0) begin
                iLCD_Ready = 1'b0;
                wst = 0;
            end else begin
                case (wst)
                    0: begin
                        iLCD_Ready = 1'b1;
                        if (oLCD_WriteEnabled) begin
                            wst = 1;
                            wcnt = hold_cyc;
                        end
                    end
                    1: begin
                        if (wcnt == 0) begin
                            iLCD_Ready = 1'b0;
                            wcnt = busy_cyc - 1;
                            wst = 2;
                        end else wcnt--;
                    end
                    default: begin
                        if (wcnt == 0) begin
                            iLCD_Ready = 1'b1;
                            wst = 0;
                        end else wcnt--;
                    end
                endcase
            end
        end
    end

    task automatic push1(input logic [7:0] d);
        @(negedge Clock);
        iPush = 1'b1;
        iPushData = d;
        @(negedge Clock);
        iPush = 1'b0;
    endtask

    task automatic push_burst(input logic [7:0] base, input int n, input bit track);
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            iPush = 1'b1;
            iPushData = base + 8'(k);
            if (track) expect_char(base + 8'(k));
        end
        @(negedge Clock);
        iPush = 1'b0;
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (oLCD_WriteEnabled) break;
        end
        check(name, int'(i < budget), 1);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge Clock);
            if (strobe_cnt >= target) break;
        end
        check(name, int'(strobe_cnt >= target), 1);
        @(negedge Clock);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            #1;
            if (exp_q.size() == 0 && !oBusy && oEmpty) begin
                done = 1'b1;
                break;
            end
        end
        check(name, int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"},   int'(oLCD_WriteEnabled), 0);
        check({tag, "_data"},     int'(oLCD_Data), 0);
        check({tag, "_col"},      int'(oColumn), 0);
        check({tag, "_busy"},     int'(oBusy), 0);
        check({tag, "_retry"},    int'(oRetryCount), 0);
        check({tag, "_count"},    int'(oCount), 0);
        check({tag, "_empty"},    int'(oEmpty), 1);
        check({tag, "_full"},     int'(oFull), 0);
        check({tag, "_overflow"}, int'(oOverflow), 0);
    endtask

    initial begin : watchdog
        #300000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        int base;
        Reset = 1'b1;
        iPush = 1'b0;
        iPushData = 8'h00;
        iLCD_Initialized = 1'b0;
        wr_en = 1;
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");
        Reset = 1'b0;

        // 1: nothing is issued before initialization
        expect_char(8'h41);
        push1(8'h41);
        repeat (10) @(negedge Clock);
        #1;
        check("t1_no_strobe_before_init", strobe_cnt, 0);
        check("t1_count_held", int'(oCount), 1);
        iLCD_Initialized = 1'b1;
        wait_idle(50, "t1_idle");
        check("t1_strobes", strobe_cnt, 1);
        check("t1_col", int'(oColumn), 1);

        // latency: push into empty FIFO, ready writer -> strobe two cycles later
        @(negedge Clock);
        iPush = 1'b1;
        iPushData = 8'h4C;
        expect_char(8'h4C);
        @(negedge Clock);
        iPush = 1'b0;
        check("lat_no_strobe_yet", int'(oLCD_WriteEnabled), 0);
        check("lat_count", int'(oCount), 1);
        @(negedge Clock);
        check("lat_strobe", int'(oLCD_WriteEnabled), 1);
        wait_idle(50, "lat_idle");

        // 2: fill with writer blocked, 17th push dropped
        wr_en = 0;
        repeat (2) @(negedge Clock);
        push_burst(8'h50, 16, 1'b1);
        check("t2_full", int'(oFull), 1);
        check("t2_count16", int'(oCount), 16);
        check("t2_no_ovf_yet", int'(oOverflow), 0);
        push1(8'h60);
        check("t2_overflow", int'(oOverflow), 1);
        check("t2_count_after_drop", int'(oCount), 16);
        wr_en = 1;
        wait_idle(400, "t2_drain");
        check("t2_col", int'(oColumn), next_col % COLS);

        // 3: late acknowledge -> re-strobes of the held char at +4 and +8
        base = strobe_cnt;
        hold_cyc = 10;
        expect_char(8'h52);
        expect_retry(8'h52);
        expect_retry(8'h52);
        push1(8'h52);
        wait_strobes(base + 1, 20, "t3_first_strobe");
        hold_cyc = 0;
        expect_char(8'h54);
        push1(8'h54);
        wait_strobes(base + 3, 40, "t3_retries_seen");
        check("t3_count_unchanged", int'(oCount), 1);
        check("t3_retry_count", int'(oRetryCount), 2);
        wait_idle(100, "t3_idle");
        check("t3_retry_final", int'(oRetryCount), 2);
        check("t3_col", int'(oColumn), 4);

        // 4: column wrap; dropping init clears the column
        @(negedge Clock);
        iLCD_Initialized = 1'b0;
        @(negedge Clock);
        check("t4_col_cleared", int'(oColumn), 0);
        check("t4_not_busy", int'(oBusy), 0);
        iLCD_Initialized = 1'b1;
        next_col = 0;
        push_burst(8'h30, 17, 1'b1);
        wait_idle(500, "t4_idle");
        check("t4_col_wrapped", int'(oColumn), 1);

        // 5a: push and pop in the same cycle at count 3
        wr_en = 0;
        repeat (2) @(negedge Clock);
        push_burst(8'h41, 3, 1'b1);
        wr_en = 1;
        wait_strobe(20, "t5_strobe");
        check("t5_count_before", int'(oCount), 3);
        iPush = 1'b1;
        iPushData = 8'h57;
        expect_char(8'h57);
        @(negedge Clock);
        iPush = 1'b0;
        check("t5_count_same", int'(oCount), 3);
        wait_idle(200, "t5_idle");

        // 5b: push at full with a pop in the same cycle is dropped
        Reset = 1'b1;
        wr_en = 0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        exp_q.delete();
        next_col = 0;
        repeat (2) @(negedge Clock);
        push_burst(8'h61, 16, 1'b1);
        check("t5b_full", int'(oFull), 1);
        check("t5b_no_ovf", int'(oOverflow), 0);
        wr_en = 1;
        wait_strobe(20, "t5b_strobe");
        iPush = 1'b1;
        iPushData = 8'h5A;
        @(negedge Clock);
        iPush = 1'b0;
        check("t5b_count", int'(oCount), 15);
        check("t5b_overflow", int'(oOverflow), 1);
        wait_idle(400, "t5b_idle");

        // 6: reset while waiting for the writer's acknowledge
        hold_cyc = 10;
        expect_char(8'h51);
        push1(8'h51);
        wait_strobe(20, "t6_strobe");
        @(negedge Clock);
        check("t6_busy", int'(oBusy), 1);
        Reset = 1'b1;
        wr_en = 0;
        @(negedge Clock);
        check_reset_outputs("t6");
        check("t6_scoreboard_empty", exp_q.size(), 0);
        Reset = 1'b0;
        hold_cyc = 0;
        repeat (3) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
